// File: rtl/mem_bus_stage.sv
// rtl/mem_bus_stage.sv - memory-access pipeline stage with single-outstanding req/ack data bus
//
// Purpose: executes LB/LH/LW/LBU/LHU/SB/SH/SW over a request/acknowledge bus,
// holds a stall request while the access is in flight, keeps the finished result
// until the pipeline advances, and forwards register-file and HI/LO write info.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   stall[5:0]         pipeline stall vector; stall[4] freezes this stage
//   aluop_i            operation code from ex_mem
//   mem_addr_i         effective byte address
//   reg2_i             store data
//   wd_i/wreg_i/wdata_i, whilo_i/hi_i/lo_i   write-back info from ex_mem
//   bus_data_i, bus_ack_i                    bus read data and acknowledge
//   wd_o/wreg_o/wdata_o, whilo_o/hi_o/lo_o   write-back info to mem_wb
//   bus_req_o/bus_we_o/bus_addr_o/bus_sel_o/bus_data_o   bus request side
//   stallreq_o         stall request to ctrl
//   misalign_o         misaligned access flag
//   bus_err_o          bus timeout flag

module mem_bus_stage #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam int unsigned CW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  state_t        state_n;

  logic          req_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   addr_q;
  logic [31:0]   wr_data_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [7:0]    op_q;
  logic [1:0]    lane_q;

  logic          is_load;
  logic          is_store;
  logic          is_mem;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          misaligned;
  logic          start;
  logic [3:0]    req_sel;
  logic [31:0]   req_data;
  logic          cnt_at_limit;
  logic          op_q_is_load;
  logic [31:0]   load_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Only stall[4] concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign is_load  = aluop_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store = aluop_i inside {OP_SB, OP_SH, OP_SW};
  assign is_mem   = is_load | is_store;
  assign is_byte  = aluop_i inside {OP_LB, OP_LBU, OP_SB};
  assign is_half  = aluop_i inside {OP_LH, OP_LHU, OP_SH};
  assign is_word  = aluop_i inside {OP_LW, OP_SW};

  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
  assign start      = is_mem & ~misaligned;

  assign cnt_at_limit = (cnt_q == CNT_LIMIT);
  assign op_q_is_load = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    req_sel  = 4'b0000;
    req_data = 32'h0;
    if (is_byte) begin
      req_sel = 4'b1000 >> mem_addr_i[1:0];
    end else if (is_half) begin
      req_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end else if (is_word) begin
      req_sel = 4'b1111;
    end
    if (is_store) begin
      if (is_byte)      req_data = {4{reg2_i[7:0]}};
      else if (is_half) req_data = {2{reg2_i[15:0]}};
      else              req_data = reg2_i;
    end
  end

  always_comb begin
    ld_byte  = 8'h0;
    ld_half  = 16'h0;
    load_ext = rdata_q;
    case (lane_q)
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = lane_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (op_q)
      OP_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_ext = {24'h0, ld_byte};
      OP_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_ext = {16'h0, ld_half};
      default: load_ext = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'b0000;
      addr_q    <= 32'h0;
      wr_data_q <= 32'h0;
      cnt_q     <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      op_q      <= 8'h0;
      lane_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_q     <= 1'b1;
            we_q      <= is_store;
            sel_q     <= req_sel;
            addr_q    <= {mem_addr_i[31:2], 2'b00};
            wr_data_q <= req_data;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            op_q      <= aluop_i;
            lane_q    <= mem_addr_i[1:0];
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack arriving on the limit cycle still completes the access cleanly.
          if (bus_ack_i) begin
            req_q <= 1'b0;
            if (op_q_is_load) rdata_q <= bus_data_i;
          end else if (cnt_at_limit) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    wd_o       = 5'h0;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    whilo_o    = 1'b0;
    hi_o       = 32'h0;
    lo_o       = 32'h0;
    bus_req_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_addr_o = 32'h0;
    bus_sel_o  = 4'b0000;
    bus_data_o = 32'h0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;

    if (rst) begin
      wd_o       = wd_i;
      wdata_o    = wdata_i;
      whilo_o    = whilo_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      bus_req_o  = req_q;
      bus_we_o   = we_q;
      bus_addr_o = addr_q;
      bus_sel_o  = sel_q;
      bus_data_o = wr_data_q;

      case (state)
        IDLE: begin
          wreg_o     = is_mem ? 1'b0 : wreg_i;
          stallreq_o = start;
          misalign_o = is_mem & misaligned;
          if (start) state_n = BUSY;
        end
        BUSY: begin
          stallreq_o = 1'b1;
          if (bus_ack_i || cnt_at_limit) state_n = DONE;
        end
        DONE: begin
          if (err_q) begin
            bus_err_o = 1'b1;
          end else begin
            wreg_o = wreg_i;
            if (op_q_is_load) wdata_o = load_ext;
          end
          if (!stall[4]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
